// File: rtl/instr_dispatcher_if.sv
// Bus between the instruction dispatcher, its program memory and the
// control unit.
//
// Handshakes:
//   memory:  mem_en is a one-cycle read request for mem_addr. mem_rdata is
//            valid on the cycle after mem_en. There is no backpressure.
//   control: run is the valid signal for instruction. While run is high,
//            instruction stays stable. done is the ready/complete signal. A
//            transfer completes on a rising clk edge where run && done.
//            done is ignored while run is low.
interface instr_dispatcher_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_en;
  logic [15:0]       mem_rdata;
  logic              done;
  logic [15:0]       instruction;
  logic              run;

  // The dispatcher side drives the memory request and the execute request.
  modport master (
    output mem_addr, mem_en, instruction, run,
    input  mem_rdata, done
  );

  // The memory and control unit side.
  modport slave (
    input  mem_addr, mem_en, instruction, run,
    output mem_rdata, done
  );
endinterface

// File: rtl/instr_dispatcher.sv
// Instruction dispatcher: fetches 16-bit words from a synchronous program
// memory and issues each one to the control unit over the run/done handshake.
// A HALT_WORD fetch stops dispatch without being issued. A watchdog flags a
// control unit that never answers.
// Optional macro SINGLE_STEP_EN adds a `step` input. Each fetched instruction
// then waits in STEP_WAIT until a step pulse releases it.
module instr_dispatcher #(
  parameter int          ADDR_W    = 8,
  parameter logic [15:0] HALT_WORD = 16'hFFFF,
  parameter int          TIMEOUT   = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
`ifdef SINGLE_STEP_EN
  input  logic              step,
`endif
  instr_dispatcher_if.master bus,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic              error,
  output logic [15:0]       retired,
  output logic [2:0]        state_dbg
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    WAIT_MEM  = 3'd2,
    EXEC      = 3'd3,
    HALTED    = 3'd4,
    ERROR     = 3'd5
`ifdef SINGLE_STEP_EN
    , STEP_WAIT = 3'd6
`endif
  } state_t;

  state_t            state, state_nxt;
  logic [WD_W-1:0]   watchdog;
  logic [15:0]       instr_q;
  logic              run_q;
  logic              is_halt;
  logic              timeout_hit;

  assign is_halt     = (bus.mem_rdata == HALT_WORD);
  // The last allowed cycle without done. On this cycle, the error fires at
  // the next edge.
  assign timeout_hit = (watchdog == WD_W'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state decode. stop has priority everywhere except EXEC. In EXEC,
  // stop is only honoured once done completes the instruction.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start) state_nxt = FETCH;
      FETCH:    state_nxt = stop ? IDLE : WAIT_MEM;
      WAIT_MEM: begin
        if (stop)         state_nxt = IDLE;
        else if (is_halt) state_nxt = HALTED;
`ifdef SINGLE_STEP_EN
        else              state_nxt = STEP_WAIT;
`else
        else              state_nxt = EXEC;
`endif
      end
`ifdef SINGLE_STEP_EN
      STEP_WAIT: begin
        if (stop)      state_nxt = IDLE;
        else if (step) state_nxt = EXEC;
      end
`endif
      EXEC: begin
        if (bus.done)         state_nxt = stop ? IDLE : FETCH;
        else if (timeout_hit) state_nxt = ERROR;
      end
      HALTED:   if (start) state_nxt = FETCH;
      ERROR:    if (start) state_nxt = FETCH;
      default:  state_nxt = IDLE;
    endcase
  end

  // Datapath: pc, the instruction latch, run, the watchdog and the retire
  // counter. All of them move together with the state transitions above.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc       <= '0;
      instr_q  <= '0;
      run_q    <= 1'b0;
      retired  <= '0;
      watchdog <= '0;
    end else begin
      case (state)
        IDLE, HALTED, ERROR: begin
          if (start) begin
            pc      <= '0;
            retired <= '0;
          end
        end
        WAIT_MEM: begin
          if (!stop && !is_halt) begin
            instr_q  <= bus.mem_rdata;
            watchdog <= '0;
`ifndef SINGLE_STEP_EN
            run_q    <= 1'b1;
`endif
          end
        end
`ifdef SINGLE_STEP_EN
        STEP_WAIT: begin
          if (!stop && step) begin
            run_q    <= 1'b1;
            watchdog <= '0;
          end
        end
`endif
        EXEC: begin
          if (bus.done) begin
            run_q <= 1'b0;
            pc    <= pc + ADDR_W'(1);
            if (retired != 16'hFFFF) retired <= retired + 16'd1;
          end else if (timeout_hit) begin
            run_q <= 1'b0;
          end else begin
            watchdog <= watchdog + WD_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from registered state.
  always_comb begin
    bus.mem_en      = (state == FETCH);
    bus.mem_addr    = pc;
    bus.instruction = instr_q;
    bus.run         = run_q;
    busy            = (state == FETCH) || (state == WAIT_MEM) || (state == EXEC)
`ifdef SINGLE_STEP_EN
                      || (state == STEP_WAIT)
`endif
                      ;
    halted          = (state == HALTED);
    error           = (state == ERROR);
    state_dbg       = state;
  end

endmodule

// File: tb/tb_instr_dispatcher.sv
// Directed bench for instr_dispatcher. The primary instance (ADDR_W=8) runs
// the program, timeout, stop and reset scenarios. A second instance
// (ADDR_W=2) exercises pc wrap-around.
module tb_instr_dispatcher;
  localparam int TIMEOUT = 15;
  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_ERROR = 3'd5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, start, stop, start2, stop2, done_en;
`ifdef SINGLE_STEP_EN
  logic step, step2;
`endif

  instr_dispatcher_if #(.ADDR_W(8)) bus ();
  instr_dispatcher_if #(.ADDR_W(2)) bus2 ();

  logic [7:0]  pc;
  logic [1:0]  pc2;
  logic        busy, halted, error, busy2, halted2, error2;
  logic [15:0] retired, retired2;
  logic [2:0]  st, st2;

  instr_dispatcher #(.ADDR_W(8), .HALT_WORD(16'hFFFF), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
`ifdef SINGLE_STEP_EN
    .step(step),
`endif
    .bus(bus), .pc(pc), .busy(busy), .halted(halted), .error(error),
    .retired(retired), .state_dbg(st)
  );

  instr_dispatcher #(.ADDR_W(2), .HALT_WORD(16'hFFFF), .TIMEOUT(TIMEOUT)) dut2 (
    .clk(clk), .reset_n(reset_n), .start(start2), .stop(stop2),
`ifdef SINGLE_STEP_EN
    .step(step2),
`endif
    .bus(bus2), .pc(pc2), .busy(busy2), .halted(halted2), .error(error2),
    .retired(retired2), .state_dbg(st2)
  );

  // ---------------- memory and control-unit models ----------------
  logic [15:0] mem [256];
  logic [15:0] mem2 [4];
  int run_cnt, run_cnt2;
  logic saw_halt_run;

  always @(posedge clk or negedge reset_n)
    if (!reset_n) bus.mem_rdata <= 16'h0;
    else if (bus.mem_en) bus.mem_rdata <= mem[bus.mem_addr];

  always @(posedge clk or negedge reset_n)
    if (!reset_n) bus2.mem_rdata <= 16'h0;
    else if (bus2.mem_en) bus2.mem_rdata <= mem2[bus2.mem_addr];

  // The 4-phase control unit answers done on the 4th cycle of run.
  always @(posedge clk) run_cnt  <= bus.run  ? run_cnt + 1  : 0;
  always @(posedge clk) run_cnt2 <= bus2.run ? run_cnt2 + 1 : 0;
  assign bus.done  = done_en && bus.run  && (run_cnt == 3);
  assign bus2.done = bus2.run && (run_cnt2 == 3);

  always @(negedge clk)
    if (bus.run && bus.instruction == 16'hFFFF) saw_halt_run = 1'b1;

  // ---------------- scoreboard ----------------
  int n_vec = 0, n_miss = 0;
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  int ret_cyc[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_run(input string tag);
    int c = 0;
    while (!bus.run && c < 50) begin @(negedge clk); c++; end
    check(tag, 32'(bus.run), 1);
  endtask

  task automatic run_len(input string tag);
    int len = 0;
    while (bus.run && len < 40) begin len++; @(negedge clk); end
    check(tag, len, 4);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int k, c;
    logic prev_run;
    logic [15:0] prev_ret;
    reset_n = 1'b0; start = 1'b0; stop = 1'b0; start2 = 1'b0; stop2 = 1'b0;
    done_en = 1'b1; saw_halt_run = 1'b0;
`ifdef SINGLE_STEP_EN
    step = 1'b0; step2 = 1'b0;
`endif
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    for (int i = 0; i < 4; i++) mem2[i] = 16'h0000;
    mem[0] = 16'h2404; mem[1] = 16'h4810; mem[2] = 16'hFFFF;

    repeat (2) @(negedge clk);
    check("rst_run", 32'(bus.run), 0);
    check("rst_mem_en", 32'(bus.mem_en), 0);
    check("rst_pc", 32'(pc), 0);
    check("rst_instr", 32'(bus.instruction), 0);
    check("rst_flags", {29'd0, busy, halted, error}, 0);
    check("rst_retired", 32'(retired), 0);
    reset_n = 1'b1;
    @(negedge clk);

`ifndef SINGLE_STEP_EN
    // ---- program run to HALT ----
    pulse_start();
    check("t1_fetch_en", 32'(bus.mem_en), 1);
    check("t1_fetch_addr", 32'(bus.mem_addr), 0);
    @(negedge clk);
    check("t1_waitmem_run", 32'(bus.run), 0);
    @(negedge clk);
    check("t1_run_latency", 32'(bus.run), 1);
    check("t1_instr0", 32'(bus.instruction), 32'h2404);
    run_len("t1_run0_len");
    wait_run("t1_run1");
    check("t1_instr1", 32'(bus.instruction), 32'h4810);
    run_len("t1_run1_len");
    k = 0;
    while (!halted && k < 20) begin @(negedge clk); k++; end
    check("t1_halted", 32'(halted), 1);
    check("t1_pc", 32'(pc), 2);
    check("t1_retired", 32'(retired), 2);
    check("t1_busy", 32'(busy), 0);
    check("t1_no_ffff_run", 32'(saw_halt_run), 0);

    // ---- watchdog timeout ----
    done_en = 1'b0;
    pulse_start();
    wait_run("t2_run");
    k = 0;
    while (!error && k < 40) begin @(negedge clk); k++; end
    check("t2_error_delay", k, TIMEOUT);
    check("t2_run_dropped", 32'(bus.run), 0);
    check("t2_state", 32'(st), 32'(S_ERROR));
    done_en = 1'b1;
    pulse_start();
    check("t2_error_clr", 32'(error), 0);
    check("t2_refetch_en", 32'(bus.mem_en), 1);
    check("t2_refetch_addr", 32'(bus.mem_addr), 0);
    check("t2_retired_clr", 32'(retired), 0);

    // ---- stop during EXEC ----
    wait_run("t3_run");
    @(negedge clk);
    stop = 1'b1;
    k = 0;
    while (bus.run && k < 20) begin @(negedge clk); k++; end
    check("t3_retired", 32'(retired), 1);
    check("t3_pc", 32'(pc), 1);
    check("t3_state", 32'(st), 32'(S_IDLE));
    check("t3_busy", 32'(busy), 0);
    stop = 1'b0;
    k = 0;
    for (int i = 0; i < 8; i++) begin @(negedge clk); if (bus.mem_en) k++; end
    check("t3_no_mem_en", k, 0);

    // ---- pc wrap on a 2-bit address space ----
    start2 = 1'b1; @(negedge clk); start2 = 1'b0;
    prev_run = 1'b0; prev_ret = retired2;
    for (c = 0; c < 40; c++) begin
      if (bus2.run && !prev_run) obs_q.push_back(8'(pc2));
      if (retired2 != prev_ret) ret_cyc.push_back(c);
      prev_run = bus2.run; prev_ret = retired2;
      @(negedge clk);
    end
    exp_q = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd0};
    check("t4_rise_count", (obs_q.size() >= 5) ? 1 : 0, 1);
    while (exp_q.size() > 0 && obs_q.size() > 0)
      check("t4_pc_seq", 32'(obs_q.pop_front()), 32'(exp_q.pop_front()));
    check("t4_retire_count", (ret_cyc.size() >= 5) ? 1 : 0, 1);
    for (int i = 1; i < 5 && i < ret_cyc.size(); i++)
      check("t4_retire_period", ret_cyc[i] - ret_cyc[i-1], 6);
    stop2 = 1'b1;
    repeat (10) @(negedge clk);
    check("t4_stopped", 32'(st2), 32'(S_IDLE));
    stop2 = 1'b0;

    // ---- asynchronous reset in the 2nd EXEC cycle ----
    pulse_start();
    wait_run("t5_run0");
    k = 0;
    while (bus.run && k < 20) begin @(negedge clk); k++; end
    wait_run("t5_run1");
    check("t5_pc_before", 32'(pc), 1);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("t5_run_async", 32'(bus.run), 0);
    check("t5_pc_async", 32'(pc), 0);
    check("t5_state_async", 32'(st), 32'(S_IDLE));
    @(negedge clk);
    reset_n = 1'b1;
    k = 0;
    for (int i = 0; i < 8; i++) begin @(negedge clk); if (bus.mem_en) k++; end
    check("t5_no_mem_en", k, 0);
`else
    // ---- single-step release ----
    pulse_start();
    k = 0;
    while (bus.instruction != 16'h2404 && k < 10) begin @(negedge clk); k++; end
    check("t6_instr_loaded", 32'(bus.instruction), 32'h2404);
    repeat (3) @(negedge clk);
    check("t6_run_held", 32'(bus.run), 0);
    check("t6_busy", 32'(busy), 1);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    check("t6_run_after_step", 32'(bus.run), 1);
    run_len("t6_run_len");
    check("t6_retired", 32'(retired), 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
